dma_scheduler: RTL and testbench

DMA_SCHEDULER -- requirements
Module: dma_scheduler

---
 rtl/dma_scheduler.sv | 133 +++++++++++++
 tb/tb_dma_scheduler.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_scheduler.sv
// Round-robin scheduler that hands one of four channel descriptors at a time to a DMA engine
// and returns a one-hot completion or timeout pulse to the granted channel.
module dma_scheduler #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_W          = 11
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [3:0]   ch_req,
  input  logic [127:0] ch_src,
  input  logic [127:0] ch_dst,
  input  logic [19:0]  ch_len,
  output logic [3:0]   ch_ack,
  output logic [3:0]   ch_err,
  output logic         busy,
  output logic [1:0]   active_ch,
  output logic         dma_reset,
  output logic         dma_trigger,
  output logic [31:0]  dma_src,
  output logic [31:0]  dma_dst,
  output logic [4:0]   dma_length,
  input  logic         dma_done
);

  typedef enum logic [2:0] {StIdle, StLoad, StTrig, StWait, StDone} state_e;

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q;
  logic [1:0]       last_grant_q;
  logic [CNT_W-1:0] cnt_q;

  logic             grant_vld;
  logic [1:0]       grant_idx;
  logic [1:0]       cand;
  logic [4:0]       grant_len;
  logic [3:0]       active_oh;
  logic [3:0]       grant_oh;

  // Scan from last_grant+4 down to last_grant+1 so the nearest requester after
  // the previous winner overwrites the others.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = last_grant_q;
    cand      = last_grant_q;
    for (int i = 4; i >= 1; i--) begin
      cand = last_grant_q + 2'(i);
      if (ch_req[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  assign grant_len = ch_len[grant_idx*5 +: 5];
  assign grant_oh  = 4'b0001 << grant_idx;
  assign active_oh = 4'b0001 << active_ch;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      last_grant_q <= 2'd3;
      cnt_q        <= '0;
      ch_ack       <= '0;
      ch_err       <= '0;
      busy         <= 1'b0;
      active_ch    <= '0;
      dma_reset    <= 1'b1;
      dma_trigger  <= 1'b0;
      dma_src      <= '0;
      dma_dst      <= '0;
      dma_length   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          ch_ack      <= '0;
          ch_err      <= '0;
          dma_reset   <= 1'b0;
          dma_trigger <= 1'b0;
          busy        <= 1'b0;
          if (grant_vld) begin
            busy       <= 1'b1;
            active_ch  <= grant_idx;
            dma_src    <= ch_src[grant_idx*32 +: 32];
            dma_dst    <= ch_dst[grant_idx*32 +: 32];
            dma_length <= grant_len;
            // Sub-word transfers complete without involving the engine.
            if (grant_len[4:2] == 3'd0) begin
              state_q <= StDone;
              ch_ack  <= grant_oh;
            end else begin
              state_q   <= StLoad;
              dma_reset <= 1'b1;
            end
          end
        end
        StLoad: begin
          dma_reset   <= 1'b0;
          dma_trigger <= 1'b1;
          state_q     <= StTrig;
        end
        StTrig: begin
          dma_trigger <= 1'b0;
          cnt_q       <= '0;
          state_q     <= StWait;
        end
        StWait: begin
          cnt_q <= cnt_q + 1'b1;
          if (dma_done) begin
            state_q   <= StDone;
            ch_ack    <= active_oh;
            dma_reset <= 1'b1;
          end else if (cnt_q == CntMax) begin
            state_q   <= StDone;
            ch_ack    <= active_oh;
            ch_err    <= active_oh;
            dma_reset <= 1'b1;
          end
        end
        StDone: begin
          ch_ack       <= '0;
          ch_err       <= '0;
          dma_reset    <= 1'b0;
          busy         <= 1'b0;
          last_grant_q <= active_ch;
          state_q      <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_scheduler.sv
// Directed-vector bench for dma_scheduler with a 16-cycle timeout.
module tb_dma_scheduler;

  logic         clk;
  logic         reset;
  logic [3:0]   ch_req;
  logic [127:0] ch_src;
  logic [127:0] ch_dst;
  logic [19:0]  ch_len;
  logic [3:0]   ch_ack;
  logic [3:0]   ch_err;
  logic         busy;
  logic [1:0]   active_ch;
  logic         dma_reset;
  logic         dma_trigger;
  logic [31:0]  dma_src;
  logic [31:0]  dma_dst;
  logic [4:0]   dma_length;
  logic         dma_done;

  int vectors;
  int miscompares;

  dma_scheduler #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .ch_req(ch_req), .ch_src(ch_src), .ch_dst(ch_dst),
    .ch_len(ch_len), .ch_ack(ch_ack), .ch_err(ch_err), .busy(busy), .active_ch(active_ch),
    .dma_reset(dma_reset), .dma_trigger(dma_trigger), .dma_src(dma_src), .dma_dst(dma_dst),
    .dma_length(dma_length), .dma_done(dma_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic set_addrs();
    for (int i = 0; i < 4; i++) begin
      ch_src[i*32 +: 32] = 32'hA000_0000 + 32'(i);
      ch_dst[i*32 +: 32] = 32'hB000_0000 + 32'(i);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; ch_req = '0; dma_done = 1'b0; ch_len = '0;
    set_addrs();
    #1 reset = 1'b0;
    #1;
    vectors++;
    if ({busy, dma_reset, dma_trigger, ch_ack, ch_err, active_ch} !== 13'b0_1_0_0000_0000_00) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b want %b",
               {busy, dma_reset, dma_trigger, ch_ack, ch_err, active_ch}, 13'b0_1_0_0000_0000_00);
    end
    vectors++;
    if ({dma_src, dma_dst, dma_length} !== 69'd0) begin
      miscompares++;
      $display("FAIL reset_desc: got %h want 0", {dma_src, dma_dst, dma_length});
    end
    tick();
    reset = 1'b1;
    tick();
    vectors++;
    if ({dma_reset, busy} !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_release: got %b want 00", {dma_reset, busy});
    end
  endtask

  task automatic test_single();
    int bad;
    bad = 0;
    ch_len = {5'd8, 5'd8, 5'd8, 5'd8};
    ch_req = 4'b0001;
    tick();
    vectors++;
    if ({busy, dma_reset, dma_trigger, active_ch} !== 5'b1_1_0_00) begin
      miscompares++;
      $display("FAIL single_load: got %b want 11000", {busy, dma_reset, dma_trigger, active_ch});
    end
    vectors++;
    if ({dma_src, dma_dst, dma_length} !== {32'hA000_0000, 32'hB000_0000, 5'd8}) begin
      miscompares++;
      $display("FAIL single_desc: got %h want %h", {dma_src, dma_dst, dma_length},
               {32'hA000_0000, 32'hB000_0000, 5'd8});
    end
    tick();
    vectors++;
    if ({dma_reset, dma_trigger} !== 2'b01) begin
      miscompares++;
      $display("FAIL single_trig: got %b want 01", {dma_reset, dma_trigger});
    end
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (dma_trigger !== 1'b0 || ch_ack !== 4'b0 || dma_reset !== 1'b0) bad++;
      if (i == 5) dma_done = 1'b1;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL single_wait: got %0d bad cycles want 0", bad);
    end
    tick();
    vectors++;
    if ({ch_ack, ch_err, dma_reset, busy} !== 10'b0001_0000_1_1) begin
      miscompares++;
      $display("FAIL single_ack: got %b want 0001000011", {ch_ack, ch_err, dma_reset, busy});
    end
    dma_done = 1'b0;
    ch_req = 4'b0;
    tick();
    vectors++;
    if ({ch_ack, ch_err, dma_reset, busy} !== 10'b0) begin
      miscompares++;
      $display("FAIL single_idle: got %b want 0", {ch_ack, ch_err, dma_reset, busy});
    end
  endtask

  task automatic test_short();
    ch_len = {5'd8, 5'd2, 5'd8, 5'd8};
    ch_req = 4'b0100;
    tick();
    vectors++;
    if ({ch_ack, ch_err, dma_reset, dma_trigger, busy, dma_length} !== {4'b0100, 4'b0, 3'b001, 5'd2}) begin
      miscompares++;
      $display("FAIL short_ack: got %b want %b", {ch_ack, ch_err, dma_reset, dma_trigger, busy, dma_length},
               {4'b0100, 4'b0, 3'b001, 5'd2});
    end
    ch_req = 4'b0;
    tick();
    vectors++;
    if ({ch_ack, dma_reset, dma_trigger, busy} !== 7'b0) begin
      miscompares++;
      $display("FAIL short_idle: got %b want 0", {ch_ack, dma_reset, dma_trigger, busy});
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_order [5];
    exp_order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    ch_len = {5'd8, 5'd8, 5'd8, 5'd8};
    ch_req = 4'b1111;
    apply_reset();
    for (int n = 0; n < 5; n++) begin
      for (int t = 0; t < 6 && dma_trigger !== 1'b1; t++) tick();
      vectors++;
      if (dma_trigger !== 1'b1 || active_ch !== exp_order[n]) begin
        miscompares++;
        $display("FAIL rr_grant%0d: got trig=%b ch=%0d want trig=1 ch=%0d", n, dma_trigger,
                 active_ch, exp_order[n]);
      end
      tick(); tick(); tick();
      dma_done = 1'b1;
      tick();
      dma_done = 1'b0;
      if (n == 4) ch_req = 4'b0;
      vectors++;
      if (ch_ack !== (4'b0001 << exp_order[n])) begin
        miscompares++;
        $display("FAIL rr_ack%0d: got %b want %b", n, ch_ack, 4'b0001 << exp_order[n]);
      end
    end
    tick();
  endtask

  task automatic test_timeout();
    int bad;
    bad = 0;
    ch_len = {5'd16, 5'd16, 5'd16, 5'd16};
    ch_req = 4'b0010;
    tick();
    tick();
    vectors++;
    if ({dma_trigger, active_ch} !== 3'b1_01) begin
      miscompares++;
      $display("FAIL to_trig: got %b want 101", {dma_trigger, active_ch});
    end
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (ch_ack !== 4'b0 || busy !== 1'b1) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL to_wait: got %0d early/bad cycles want 0", bad);
    end
    tick();
    vectors++;
    if ({ch_ack, ch_err, dma_reset} !== 9'b0010_0010_1) begin
      miscompares++;
      $display("FAIL to_ack: got %b want 001000101", {ch_ack, ch_err, dma_reset});
    end
    ch_req = 4'b0001;
    for (int t = 0; t < 8 && dma_trigger !== 1'b1; t++) tick();
    tick();
    dma_done = 1'b1;
    tick();
    dma_done = 1'b0;
    ch_req = 4'b0;
    vectors++;
    if ({ch_ack, ch_err} !== 8'b0001_0000) begin
      miscompares++;
      $display("FAIL to_next: got %b want 00010000", {ch_ack, ch_err});
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int acks;
    acks = 0;
    ch_len = {5'd12, 5'd12, 5'd12, 5'd12};
    ch_req = 4'b1000;
    tick(); tick(); tick(); tick();
    reset = 1'b0;
    #1;
    vectors++;
    if ({busy, dma_reset, dma_trigger, ch_ack, ch_err, active_ch} !== 13'b0_1_0_0000_0000_00) begin
      miscompares++;
      $display("FAIL rmid_ctrl: got %b want %b",
               {busy, dma_reset, dma_trigger, ch_ack, ch_err, active_ch}, 13'b0_1_0_0000_0000_00);
    end
    vectors++;
    if ({dma_src, dma_dst, dma_length} !== 69'd0) begin
      miscompares++;
      $display("FAIL rmid_desc: got %h want 0", {dma_src, dma_dst, dma_length});
    end
    ch_req = 4'b1001;
    dma_done = 1'b1;
    tick();
    if (ch_ack !== 4'b0) acks++;
    tick();
    if (ch_ack !== 4'b0) acks++;
    dma_done = 1'b0;
    reset = 1'b1;
    tick();
    vectors++;
    if ({acks[1:0], busy, dma_reset, active_ch} !== 6'b00_1_1_00) begin
      miscompares++;
      $display("FAIL rmid_regrant: got %b want 001100", {acks[1:0], busy, dma_reset, active_ch});
    end
    tick(); tick();
    dma_done = 1'b1;
    tick();
    dma_done = 1'b0;
    ch_req = 4'b0;
    vectors++;
    if (ch_ack !== 4'b0001) begin
      miscompares++;
      $display("FAIL rmid_ack: got %b want 0001", ch_ack);
    end
    tick();
  endtask

  task automatic test_done_ignored();
    int spurious;
    int acks;
    spurious = 0;
    acks = 0;
    ch_req = 4'b0;
    for (int i = 0; i < 4; i++) begin
      dma_done = (i % 2 == 0);
      tick();
      if (ch_ack !== 4'b0 || busy !== 1'b0) spurious++;
    end
    dma_done = 1'b0;
    vectors++;
    if (spurious != 0) begin
      miscompares++;
      $display("FAIL idle_done: got %0d spurious cycles want 0", spurious);
    end
    ch_len = {5'd8, 5'd8, 5'd8, 5'd8};
    ch_req = 4'b0100;
    tick();
    dma_done = 1'b1;
    tick();
    dma_done = 1'b0;
    tick();
    ch_req = 4'b0;
    ch_len = '0;
    ch_src = '0;
    tick(); tick();
    vectors++;
    if ({ch_ack, busy, active_ch, dma_length, dma_src} !== {4'b0, 1'b1, 2'd2, 5'd8, 32'hA000_0002}) begin
      miscompares++;
      $display("FAIL drop_hold: got %h want %h", {ch_ack, busy, active_ch, dma_length, dma_src},
               {4'b0, 1'b1, 2'd2, 5'd8, 32'hA000_0002});
    end
    dma_done = 1'b1;
    tick();
    dma_done = 1'b0;
    if (ch_ack === 4'b0100) acks++;
    tick();
    if (ch_ack !== 4'b0) acks++;
    tick();
    if (ch_ack !== 4'b0 || busy !== 1'b0) acks++;
    vectors++;
    if (acks != 1) begin
      miscompares++;
      $display("FAIL drop_ack: got %0d ack events want 1", acks);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_single();
    test_short();
    test_round_robin();
    test_timeout();
    test_reset_mid();
    set_addrs();
    test_done_ignored();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
